// File: rtl/mv_fetch_pkg.sv
// mv_fetch_pkg: shared FSM state encoding and FIFO depth for the matrix-vector fetch unit
package mv_fetch_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_VEC, STREAM, DRAIN, DONE} state_e;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: two-entry synchronous FIFO; head reads as zero while empty
module fetch_fifo2
  import mv_fetch_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = (cnt_q != 2'd0) ? mem_q[rd_q] : '0;
  assign count = cnt_q;
endmodule

// File: rtl/mv_fetch_unit.sv
// mv_fetch_unit: loads an N-vector, then streams an NxN row-major matrix paired with vector elements
module mv_fetch_unit
  import mv_fetch_pkg::*;
#(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16,
  parameter int MAX_N     = 8,
  parameter int DIM_W     = $clog2(MAX_N + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIM_W-1:0]     n_dim,
  input  logic [ADD_SIZE-1:0]  mat_base,
  input  logic [ADD_SIZE-1:0]  vec_base,
  output logic                 mem_rd,
  output logic [ADD_SIZE-1:0]  mem_addr,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_mat,
  output logic [DATA_SIZE-1:0] out_vec,
  output logic                 out_last_col,
  output logic                 out_last_row,
  output logic                 busy,
  output logic                 done
);
  localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int FW = 2 * DATA_SIZE + 2;
  state_e state_q, state_d;
  logic [ADD_SIZE-1:0] addr_q, addr_d, mat_base_q, mat_base_d;
  logic [IW-1:0] nm1_q, nm1_d, c_q, c_d, r_q, r_d, vec_idx_q, vec_idx_d, pend_c_q, pend_c_d;
  logic vec_wr_q, vec_wr_d, pend_q, pend_d, pend_lc_q, pend_lc_d, pend_lr_q, pend_lr_d;
  logic [DATA_SIZE-1:0] vec_buf [MAX_N];
  logic [FW-1:0] fifo_dout;
  logic [1:0] fifo_cnt, occ;
  logic pop, last_c, last_r, start_ok;
  assign out_valid = fifo_cnt != 2'd0;
  assign pop = out_valid && out_ready;
  assign last_c = c_q == nm1_q;
  assign last_r = r_q == nm1_q;
  assign start_ok = start && n_dim != '0 && n_dim <= DIM_W'(MAX_N);
  // Occupancy counts the slot freed by this cycle's pop so a steady stream issues every cycle
  assign occ = fifo_cnt - {1'b0, pop} + {1'b0, pend_q};
  assign mem_rd = state_q == LOAD_VEC || (state_q == STREAM && !occ[1]);
  assign mem_addr = mem_rd ? addr_q : '0;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign {out_mat, out_vec, out_last_col, out_last_row} = fifo_dout;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    mat_base_d = mat_base_q;
    nm1_d = nm1_q;
    c_d = c_q;
    r_d = r_q;
    vec_wr_d = 1'b0;
    vec_idx_d = vec_idx_q;
    pend_d = 1'b0;
    pend_c_d = pend_c_q;
    pend_lc_d = pend_lc_q;
    pend_lr_d = pend_lr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = start_ok ? LOAD_VEC : DONE;
        addr_d = vec_base;
        mat_base_d = mat_base;
        nm1_d = IW'(n_dim - 1'b1);
        c_d = '0;
        r_d = '0;
      end
      LOAD_VEC: begin
        vec_wr_d = 1'b1;
        vec_idx_d = c_q;
        addr_d = last_c ? mat_base_q : addr_q + 1'b1;
        c_d = last_c ? '0 : c_q + 1'b1;
        state_d = last_c ? STREAM : LOAD_VEC;
      end
      STREAM: if (mem_rd) begin
        pend_d = 1'b1;
        pend_c_d = c_q;
        pend_lc_d = last_c;
        pend_lr_d = last_r;
        addr_d = addr_q + 1'b1;
        c_d = last_c ? '0 : c_q + 1'b1;
        r_d = last_c ? r_q + 1'b1 : r_q;
        state_d = (last_c && last_r) ? DRAIN : STREAM;
      end
      DRAIN: if (!pend_q && fifo_cnt == 2'd1 && pop) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      mat_base_q <= '0;
      nm1_q <= '0;
      c_q <= '0;
      r_q <= '0;
      vec_wr_q <= 1'b0;
      vec_idx_q <= '0;
      pend_q <= 1'b0;
      pend_c_q <= '0;
      pend_lc_q <= 1'b0;
      pend_lr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      mat_base_q <= mat_base_d;
      nm1_q <= nm1_d;
      c_q <= c_d;
      r_q <= r_d;
      vec_wr_q <= vec_wr_d;
      vec_idx_q <= vec_idx_d;
      pend_q <= pend_d;
      pend_c_q <= pend_c_d;
      pend_lc_q <= pend_lc_d;
      pend_lr_q <= pend_lr_d;
    end
  end
  always_ff @(posedge clk) if (vec_wr_q) vec_buf[vec_idx_q] <= mem_rdata;
  // Vector element is looked up when the matrix word returns, after the last vector word has landed
  fetch_fifo2 #(.W(FW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(pend_q),
    .pop(pop),
    .din({mem_rdata, vec_buf[pend_c_q], pend_lc_q, pend_lr_q}),
    .dout(fifo_dout),
    .count(fifo_cnt)
  );
endmodule

// File: tb/tb_mv_fetch_unit.sv
// tb_mv_fetch_unit: scoreboard bench with random memory contents and a queue-based reference model
module tb_mv_fetch_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [3:0] n_dim = '0;
  logic [15:0] mat_base = '0, vec_base = '0, mem_rdata = '0;
  logic mem_rd, out_valid, out_last_col, out_last_row, busy, done;
  logic [15:0] mem_addr, out_mat, out_vec;
  logic [15:0] mem [65536];
  logic [33:0] exp_q [$];
  logic [15:0] addr_q [$];
  logic [33:0] cur_pair, held;
  int ncmp = 0, nerr = 0, cyc = 0, mode = 0, cur_n = 0;
  int rd_cnt = 0, valid_cnt = 0, xfer_cnt = 0, first_valid_cyc = -1, last_xfer_cyc = -1;
  int done_cnt = 0, done_cyc = -1, ahead_max = 0, start_cyc = 0;
  bit stalled = 0;
  always #5 clk = ~clk;
  mv_fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .n_dim(n_dim), .mat_base(mat_base),
    .vec_base(vec_base), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_mat(out_mat), .out_vec(out_vec),
    .out_last_col(out_last_col), .out_last_row(out_last_row), .busy(busy), .done(done)
  );
  assign cur_pair = {out_mat, out_vec, out_last_col, out_last_row};
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 16'($urandom);
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~out_ready : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  always @(negedge clk) begin
    if (reset) stalled = 0;
    else begin
      if (rd_cnt > cur_n && rd_cnt - cur_n - xfer_cnt > ahead_max) ahead_max = rd_cnt - cur_n - xfer_cnt;
      if (mem_rd) begin
        rd_cnt++;
        if (addr_q.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL rd_addr: unexpected read at %0h", mem_addr);
        end else chk("rd_addr", mem_addr, addr_q.pop_front());
      end
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_stable", cur_pair, held);
      end
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_ready) begin
          xfer_cnt++;
          last_xfer_cyc = cyc;
          if (exp_q.size() == 0) begin
            ncmp++; nerr++;
            $display("FAIL pair: unexpected pair %0h", cur_pair);
          end else chk("pair", cur_pair, exp_q.pop_front());
        end
      end
      stalled = out_valid && !out_ready;
      held = cur_pair;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end
  task automatic fill(input logic [15:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) mem[16'(base + i)] = 16'($urandom);
  endtask
  task automatic expect_job(input int n, input logic [15:0] vb, input logic [15:0] mb);
    cur_n = n;
    for (int i = 0; i < n; i++) addr_q.push_back(16'(vb + i));
    for (int k = 0; k < n * n; k++) addr_q.push_back(16'(mb + k));
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        exp_q.push_back({mem[16'(mb + r * n + c)], mem[16'(vb + c)], c == n - 1, r == n - 1});
    rd_cnt = 0; valid_cnt = 0; xfer_cnt = 0; first_valid_cyc = -1; last_xfer_cyc = -1;
    done_cnt = 0; done_cyc = -1; ahead_max = 0;
  endtask
  task automatic issue_start(input int nd, input logic [15:0] vb, input logic [15:0] mb);
    @(posedge clk);
    #1 start = 1'b1; n_dim = 4'(nd); vec_base = vb; mat_base = mb;
    @(posedge clk);
    #1 start = 1'b0; start_cyc = cyc;
    n_dim = 4'($urandom); vec_base = 16'($urandom); mat_base = 16'($urandom);
  endtask
  task automatic run_job(input int nd, input logic [15:0] vb, input logic [15:0] mb, input int md, input bit restart);
    int n;
    n = (nd >= 1 && nd <= 8) ? nd : 0;
    mode = md;
    expect_job(n, vb, mb);
    issue_start(nd, vb, mb);
    if (restart) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1; n_dim = 4'd2;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("done_count", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("rd_count", rd_cnt, n + n * n);
    chk("pairs_left", exp_q.size(), 0);
    chk("addrs_left", addr_q.size(), 0);
    if (n > 0) begin
      chk("latency", first_valid_cyc, start_cyc + n + 2);
      chk("done_timing", done_cyc, last_xfer_cyc + 1);
      chk("ahead_max", ahead_max <= 2, 1);
      if (md == 0) chk("throughput", last_xfer_cyc - first_valid_cyc, n * n - 1);
    end else begin
      chk("no_valid", valid_cnt, 0);
      chk("done_timing0", done_cyc, start_cyc);
    end
    exp_q.delete();
    addr_q.delete();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {mem_rd, mem_addr, out_valid, out_mat, out_vec, out_last_col, out_last_row, busy, done}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    mem[16'h10] = 16'd5; mem[16'h11] = 16'd6;
    for (int i = 0; i < 4; i++) mem[i] = 16'(i + 1);
    run_job(2, 16'h0010, 16'h0000, 0, 0);
    fill(16'h0100, 3); fill(16'h0200, 9);
    run_job(3, 16'h0100, 16'h0200, 1, 0);
    fill(16'h0300, 8); fill(16'h0400, 64);
    run_job(8, 16'h0300, 16'h0400, 0, 0);
    run_job(0, 16'h0500, 16'h0600, 0, 0);
    run_job(12, 16'h0500, 16'h0600, 0, 0);
    fill(16'h0700, 2); fill(16'hFFFE, 4);
    run_job(2, 16'h0700, 16'hFFFE, 2, 0);
    for (int j = 0; j < 6; j++) begin
      int nd;
      logic [15:0] vb, mb;
      nd = $urandom_range(1, 8);
      vb = 16'($urandom); mb = 16'($urandom);
      fill(vb, nd); fill(mb, nd * nd);
      run_job(nd, vb, mb, 2, nd >= 3);
    end
    fill(16'h0800, 3); fill(16'h0900, 9);
    mode = 3;
    expect_job(3, 16'h0800, 16'h0900);
    issue_start(3, 16'h0800, 16'h0900);
    for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_outputs", {mem_rd, mem_addr, out_valid, out_mat, out_vec, out_last_col, out_last_row, busy, done}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    fill(16'h0A00, 1); fill(16'h0B00, 1);
    run_job(1, 16'h0A00, 16'h0B00, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
